// File: rtl/msrv32_machine_control_if.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_machine_control_if
// Brief    : Event inputs and trap/CSR control outputs of the machine control.
// Revision : 1.0  initial release
// ============================================================================
interface msrv32_machine_control_if;
  logic       illegal_instr_in;
  logic       misaligned_instr_in;
  logic       misaligned_load_in;
  logic       misaligned_store_in;
  logic       ecall_in;
  logic       ebreak_in;
  logic       mret_in;
  logic       mie_in;
  logic       meie_in;
  logic       msie_in;
  logic       mtie_in;
  logic       meip_in;
  logic       msip_in;
  logic       mtip_in;
  logic       flush_out;
  logic [1:0] pc_src_out;
  logic       trap_taken_out;
  logic       set_cause_out;
  logic       set_epc_out;
  logic [3:0] cause_out;
  logic       i_or_e_out;
  logic       mie_clear_out;
  logic       mie_set_out;
  logic       misaligned_exception_out;
  logic       instret_inc_out;

  modport master (
    output illegal_instr_in, misaligned_instr_in, misaligned_load_in,
           misaligned_store_in, ecall_in, ebreak_in, mret_in, mie_in,
           meie_in, msie_in, mtie_in, meip_in, msip_in, mtip_in,
    input  flush_out, pc_src_out, trap_taken_out, set_cause_out, set_epc_out,
           cause_out, i_or_e_out, mie_clear_out, mie_set_out,
           misaligned_exception_out, instret_inc_out
  );

  modport slave (
    input  illegal_instr_in, misaligned_instr_in, misaligned_load_in,
           misaligned_store_in, ecall_in, ebreak_in, mret_in, mie_in,
           meie_in, msie_in, mtie_in, meip_in, msip_in, mtip_in,
    output flush_out, pc_src_out, trap_taken_out, set_cause_out, set_epc_out,
           cause_out, i_or_e_out, mie_clear_out, mie_set_out,
           misaligned_exception_out, instret_inc_out
  );
endinterface
`default_nettype wire

// File: rtl/msrv32_machine_control.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_machine_control
// Brief    : Trap/return sequencer driving pipeline flush, PC select and CSR
//            trap updates for the RV32 core.
// Revision : 1.0  initial release
// ============================================================================
module msrv32_machine_control (
  input  wire logic                     ms_riscv32_mp_clk_in,
  input  wire logic                     ms_riscv32_mp_rst_in,
  msrv32_machine_control_if.slave       bus
);

  localparam logic [1:0] RESET       = 2'b00;
  localparam logic [1:0] OPERATING   = 2'b01;
  localparam logic [1:0] TRAP_TAKEN  = 2'b10;
  localparam logic [1:0] TRAP_RETURN = 2'b11;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       exc;
  logic       irq;
  logic [3:0] next_cause;
  logic [3:0] cause;
  logic       i_or_e;

  always_comb begin
    exc = bus.illegal_instr_in | bus.misaligned_instr_in | bus.misaligned_load_in |
          bus.misaligned_store_in | bus.ecall_in | bus.ebreak_in;
    irq = bus.mie_in & ((bus.meie_in & bus.meip_in) |
                        (bus.msie_in & bus.msip_in) |
                        (bus.mtie_in & bus.mtip_in));
  end

  // Exceptions outrank interrupts; within each group the chain order is priority.
  always_comb begin
    next_cause = 4'd0;
    if (bus.misaligned_instr_in)                next_cause = 4'd0;
    else if (bus.illegal_instr_in)              next_cause = 4'd2;
    else if (bus.ebreak_in)                     next_cause = 4'd3;
    else if (bus.misaligned_load_in)            next_cause = 4'd4;
    else if (bus.misaligned_store_in)           next_cause = 4'd6;
    else if (bus.ecall_in)                      next_cause = 4'd11;
    else if (bus.meie_in & bus.meip_in)         next_cause = 4'd11;
    else if (bus.msie_in & bus.msip_in)         next_cause = 4'd3;
    else if (bus.mtie_in & bus.mtip_in)         next_cause = 4'd7;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state <= RESET;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = OPERATING;
    case (state)
      RESET:       next_state = OPERATING;
      OPERATING: begin
        if (exc || irq)      next_state = TRAP_TAKEN;
        else if (bus.mret_in) next_state = TRAP_RETURN;
        else                 next_state = OPERATING;
      end
      TRAP_TAKEN:  next_state = OPERATING;
      TRAP_RETURN: next_state = OPERATING;
      default:     next_state = RESET;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      cause  <= 4'd0;
      i_or_e <= 1'b0;
    end else if (state == OPERATING && (exc || irq)) begin
      cause  <= next_cause;
      i_or_e <= ~exc;
    end
  end

  logic       flush;
  logic [1:0] pc_src;
  logic       trap_taken;
  logic       mie_set;
  logic       instret_inc;

  always_comb begin
    flush       = 1'b0;
    pc_src      = 2'b11;
    trap_taken  = 1'b0;
    mie_set     = 1'b0;
    instret_inc = 1'b0;
    case (state)
      RESET: begin
        flush  = 1'b1;
        pc_src = 2'b00;
      end
      OPERATING: begin
        pc_src      = 2'b11;
        instret_inc = ~exc & ~irq;
      end
      TRAP_TAKEN: begin
        flush      = 1'b1;
        pc_src     = 2'b10;
        trap_taken = 1'b1;
      end
      TRAP_RETURN: begin
        flush   = 1'b1;
        pc_src  = 2'b01;
        mie_set = 1'b1;
      end
      default: begin
        flush  = 1'b1;
        pc_src = 2'b00;
      end
    endcase
  end

  assign bus.flush_out                = flush;
  assign bus.pc_src_out               = pc_src;
  assign bus.trap_taken_out           = trap_taken;
  assign bus.set_cause_out            = trap_taken;
  assign bus.set_epc_out              = trap_taken;
  assign bus.mie_clear_out            = trap_taken;
  assign bus.mie_set_out              = mie_set;
  assign bus.instret_inc_out          = instret_inc;
  assign bus.cause_out                = cause;
  assign bus.i_or_e_out               = i_or_e;
  assign bus.misaligned_exception_out = trap_taken & ~i_or_e &
                                        (cause == 4'd0 || cause == 4'd4 || cause == 4'd6);

endmodule
`default_nettype wire

// File: tb/tb_msrv32_machine_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_msrv32_machine_control
// Brief    : Directed plus randomized bench with a behavioural trap model.
// Revision : 1.0  initial release
// ============================================================================
module tb_msrv32_machine_control;

  // Event vector bit positions
  localparam int B_ILL  = 0;
  localparam int B_MIN  = 1;
  localparam int B_MLD  = 2;
  localparam int B_MST  = 3;
  localparam int B_ECA  = 4;
  localparam int B_EBR  = 5;
  localparam int B_MRET = 6;
  localparam int B_MIE  = 7;
  localparam int B_MEIE = 8;
  localparam int B_MSIE = 9;
  localparam int B_MTIE = 10;
  localparam int B_MEIP = 11;
  localparam int B_MSIP = 12;
  localparam int B_MTIP = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] ev  = '0;
  int          compared   = 0;
  int          mismatched = 0;

  // Behavioural model: which kind of cycle the core is in
  bit          m_boot;
  bit          m_trap;
  bit          m_ret;
  logic [3:0]  m_cause;
  bit          m_intr;

  always #5 clk = ~clk;

  msrv32_machine_control_if bus ();

  assign bus.illegal_instr_in    = ev[B_ILL];
  assign bus.misaligned_instr_in = ev[B_MIN];
  assign bus.misaligned_load_in  = ev[B_MLD];
  assign bus.misaligned_store_in = ev[B_MST];
  assign bus.ecall_in            = ev[B_ECA];
  assign bus.ebreak_in           = ev[B_EBR];
  assign bus.mret_in             = ev[B_MRET];
  assign bus.mie_in              = ev[B_MIE];
  assign bus.meie_in             = ev[B_MEIE];
  assign bus.msie_in             = ev[B_MSIE];
  assign bus.mtie_in             = ev[B_MTIE];
  assign bus.meip_in             = ev[B_MEIP];
  assign bus.msip_in             = ev[B_MSIP];
  assign bus.mtip_in             = ev[B_MTIP];

  msrv32_machine_control dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .bus                  (bus.slave)
  );

  function automatic bit has_exc(input logic [13:0] e);
    return |e[5:0];
  endfunction

  function automatic bit has_irq(input logic [13:0] e);
    return e[B_MIE] & ((e[B_MEIE] & e[B_MEIP]) | (e[B_MSIE] & e[B_MSIP]) |
                       (e[B_MTIE] & e[B_MTIP]));
  endfunction

  // Highest-priority cause, scanning the architectural priority tables
  function automatic logic [3:0] pick_cause(input logic [13:0] e);
    int exc_bit [6] = '{B_MIN, B_ILL, B_EBR, B_MLD, B_MST, B_ECA};
    int exc_code[6] = '{0, 2, 3, 4, 6, 11};
    int irq_en  [3] = '{B_MEIE, B_MSIE, B_MTIE};
    int irq_pd  [3] = '{B_MEIP, B_MSIP, B_MTIP};
    int irq_code[3] = '{11, 3, 7};
    for (int i = 0; i < 6; i++)
      if (e[exc_bit[i]]) return 4'(exc_code[i]);
    for (int i = 0; i < 3; i++)
      if (e[irq_en[i]] && e[irq_pd[i]]) return 4'(irq_code[i]);
    return 4'd0;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_trap  = 1'b0;
    m_ret   = 1'b0;
    m_cause = 4'd0;
    m_intr  = 1'b0;
  endtask

  task automatic check_all();
    bit         run;
    logic [1:0] pc;
    bit         mis;
    run = !(m_boot || m_trap || m_ret);
    pc  = m_boot ? 2'd0 : m_trap ? 2'd2 : m_ret ? 2'd1 : 2'd3;
    mis = m_trap && !m_intr && (m_cause == 4'd0 || m_cause == 4'd4 || m_cause == 4'd6);
    check("flush",      {3'b0, bus.flush_out},                {3'b0, !run});
    check("pc_src",     {2'b0, bus.pc_src_out},               {2'b0, pc});
    check("trap_taken", {3'b0, bus.trap_taken_out},           {3'b0, m_trap});
    check("set_cause",  {3'b0, bus.set_cause_out},            {3'b0, m_trap});
    check("set_epc",    {3'b0, bus.set_epc_out},              {3'b0, m_trap});
    check("mie_clear",  {3'b0, bus.mie_clear_out},            {3'b0, m_trap});
    check("mie_set",    {3'b0, bus.mie_set_out},              {3'b0, m_ret});
    check("cause",      bus.cause_out,                        m_cause);
    check("i_or_e",     {3'b0, bus.i_or_e_out},               {3'b0, m_intr});
    check("misaligned", {3'b0, bus.misaligned_exception_out}, {3'b0, mis});
    check("instret",    {3'b0, bus.instret_inc_out},
          {3'b0, run && !has_exc(ev) && !has_irq(ev)});
  endtask

  task automatic model_advance();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_trap || m_ret) begin
      m_trap = 1'b0;
      m_ret  = 1'b0;
    end else if (has_exc(ev) || has_irq(ev)) begin
      m_trap  = 1'b1;
      m_cause = pick_cause(ev);
      m_intr  = !has_exc(ev);
    end else if (ev[B_MRET]) begin
      m_ret = 1'b1;
    end
  endtask

  // Apply one cycle of inputs, check mid-cycle, then cross the rising edge
  task automatic step(input logic [13:0] e);
    ev = e;
    #1;
    check_all();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  function automatic logic [13:0] rand_ev();
    logic [13:0] e = '0;
    for (int i = 0; i < 6; i++) e[i] = ($urandom_range(0, 11) == 0);
    e[B_MRET] = ($urandom_range(0, 7) == 0);
    e[B_MIE]  = 1'($urandom_range(0, 1));
    for (int i = B_MEIE; i <= B_MTIE; i++) e[i] = 1'($urandom_range(0, 1));
    for (int i = B_MEIP; i <= B_MTIP; i++) e[i] = ($urandom_range(0, 5) == 0);
    return e;
  endfunction

  initial begin
    logic [13:0] e;
    model_reset();
    @(negedge clk);
    #1;
    check_all();
    rst = 1'b0;

    step('0);
    step('0);

    e = '0; e[B_ILL] = 1'b1; e[B_ECA] = 1'b1;
    step(e);
    step('0);
    step('0);

    e = '0; e[B_MIE] = 1'b1; e[B_MTIP] = 1'b1; e[B_MTIE] = 1'b1;
    e[B_MEIP] = 1'b1; e[B_MEIE] = 1'b1;
    step(e);
    step('0);
    e[B_MIE] = 1'b0;
    step(e);
    step('0);

    e = '0; e[B_MRET] = 1'b1;
    step(e);
    step('0);
    e[B_MST] = 1'b1;
    step(e);
    step('0);

    e = '0; e[B_ILL] = 1'b1; e[B_MIE] = 1'b1; e[B_MSIE] = 1'b1; e[B_MSIP] = 1'b1;
    e[B_MRET] = 1'b1;
    step(e);
    step('0);

    e = '0; e[B_EBR] = 1'b1;
    step(e);
    step(e);
    step(e);

    // Second trap: assert reset partway through the flush cycle
    ev = '0;
    #1;
    check_all();
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step('0);
    step('0);

    for (int n = 0; n < 400; n++) step(rand_ev());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msrv32_machine_control.md
# msrv32_machine_control

Trap/return sequencer for the RV32 core that produces the pipeline flush and CSR trap controls. It watches exception, interrupt and mret conditions from the execute stage, walks a four-state machine, and drives `flush_out` and the PC source select. `flush_out` is consumed by the write-enable gating logic to suppress integer-register-file and CSR writes of the squashed instruction. It also drives cause, epc and mie updates into the CSR file.

## Interface
- No parameters.
- `ms_riscv32_mp_clk_in` — input, 1 — core clock; all state updates on rising edge.
- `ms_riscv32_mp_rst_in` — input, 1 — reset, asynchronous, active-high.
- `illegal_instr_in` — input, 1 — illegal instruction in execute.
- `misaligned_instr_in` — input, 1 — misaligned fetch target.
- `misaligned_load_in` — input, 1 — misaligned load address.
- `misaligned_store_in` — input, 1 — misaligned store address.
- `ecall_in`, `ebreak_in`, `mret_in` — input, 1 each — decoded system instruction.
- `mie_in` — input, 1 — mstatus.MIE.
- `meie_in`, `msie_in`, `mtie_in` — input, 1 each — per-source interrupt enables.
- `meip_in`, `msip_in`, `mtip_in` — input, 1 each — per-source interrupt pending.
- `flush_out` — output, 1 — squash the instruction in the register stage.
- `pc_src_out` — output, 2 — 00 boot, 01 mepc, 10 trap vector, 11 next PC.
- `trap_taken_out` — output, 1 — high in the trap-entry cycle.
- `set_cause_out`, `set_epc_out` — output, 1 each — CSR write strobes.
- `cause_out` — output, 4 — registered trap cause code.
- `i_or_e_out` — output, 1 — 1 = interrupt, 0 = exception (mcause[31]).
- `mie_clear_out` — output, 1 — MPIE←MIE, MIE←0.
- `mie_set_out` — output, 1 — MIE←MPIE.
- `misaligned_exception_out` — output, 1 — current trap is a misaligned cause.
- `instret_inc_out` — output, 1 — retire strobe for minstret.

## Operation
- States, 2-bit:
  - RESET = 00
  - OPERATING = 01
  - TRAP_TAKEN = 10
  - TRAP_RETURN = 11
- Transitions:
  - RESET → OPERATING unconditionally.
  - OPERATING → TRAP_TAKEN if `exc` or `irq`.
  - OPERATING → TRAP_RETURN if `mret_in` and no `exc` and no `irq`.
  - OPERATING → OPERATING otherwise.
  - TRAP_TAKEN → OPERATING; TRAP_RETURN → OPERATING.
- `exc` is the OR of the six exception inputs.
- `irq` = `mie_in` & ((`meie_in`&`meip_in`) | (`msie_in`&`msip_in`) | (`mtie_in`&`mtip_in`)).
- Exceptions outrank interrupts. Exception cause priority:
  - misaligned_instr = 0
  - illegal = 2
  - ebreak = 3
  - misaligned_load = 4
  - misaligned_store = 6
  - ecall = 11
- Interrupt cause priority: external = 11, software = 3, timer = 7.
- `cause_out` and `i_or_e_out` are registered only on the OPERATING→TRAP_TAKEN edge and hold their value otherwise.
- `misaligned_exception_out` = TRAP_TAKEN & !`i_or_e_out` & `cause_out` ∈ {0, 4, 6}.
- Outputs decoded from state:
  - `flush_out` = 1 in RESET, TRAP_TAKEN and TRAP_RETURN.
  - `pc_src_out`: RESET = 00, OPERATING = 11, TRAP_TAKEN = 10, TRAP_RETURN = 01.
  - `trap_taken_out`, `set_cause_out`, `set_epc_out`, `mie_clear_out` = 1 only in TRAP_TAKEN.
  - `mie_set_out` = 1 only in TRAP_RETURN.
  - `instret_inc_out` = OPERATING & !`exc` & !`irq`. mret counts as retired.
- In TRAP_TAKEN and TRAP_RETURN, all event inputs are ignored (they belong to the flushed instruction).

## Timing
- Reset:
  - state = RESET, `cause_out` = 0, `i_or_e_out` = 0.
  - Therefore `flush_out` = 1, `pc_src_out` = 00, and all strobes = 0.
- First rising edge after reset deassertion: OPERATING.
- An event sampled at edge N produces TRAP_TAKEN or TRAP_RETURN outputs during cycle N+1. OPERATING resumes at N+2.
- A trap costs exactly one flush cycle.
- Back-to-back events: an event present in the cycle after a trap is ignored; an event present two cycles later is honoured.
- Reset asserted mid-TRAP_TAKEN: forces RESET immediately (asynchronously) and clears `cause_out`.
- Simultaneous exception + interrupt + mret: exception wins; the mret is dropped.

## Test plan
- Reset pulse, then idle → RESET: `flush_out`=1, `pc_src_out`=00. Next edge: OPERATING, `pc_src_out`=11, `instret_inc_out`=1.
- `illegal_instr_in`=1 and `ecall_in`=1 for one cycle → next cycle: `cause_out`=2, `i_or_e_out`=0, `flush_out`=1, `pc_src_out`=10, `set_epc_out`=1. Following cycle: OPERATING.
- `mie_in`=1, `mtip_in`=`mtie_in`=1 and `meip_in`=`meie_in`=1 → `cause_out`=11, `i_or_e_out`=1. Same with `mie_in`=0 → no trap, `instret_inc_out`=1.
- `mret_in`=1 alone → next cycle: `pc_src_out`=01, `mie_set_out`=1, `flush_out`=1. With `misaligned_store_in`=1 added → TRAP_TAKEN, `cause_out`=6, `misaligned_exception_out`=1.
- `ebreak_in` held high 3 cycles → states TRAP_TAKEN, OPERATING, TRAP_TAKEN. Reset asserted during the second TRAP_TAKEN → immediate `pc_src_out`=00, `cause_out`=0.
